bat_ram_arbiter: RTL
====================

# bat_ram_arbiter

Two-port arbiter sharing the single MAR/RAM path between the microcoded CPU controller (port 0) and the program loader/DMA engine (port 1). It grants one requester at a time, sequences each access as MAR-load then RAM-enable, and returns read data with a one-cycle acknowledge pulse. Fairness is round-robin, with bounded lock bursts. It sits between the requesters and the MAR/RAM control pins.

## Interface
- ADDR_W, 8: MAR/RAM address width.
- DATA_W, 16: RAM word width.
- MAX_BURST, 4: maximum consecutive locked transfers while the other port is waiting.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- REQ  in  2  access request; bit0 = CPU, bit1 = loader.
- LOCK  in  2  per port; requests retention of the grant for the next transfer.
- RW  in  2  per port; 1 = read, 0 = write.
- ADDR0, ADDR1  in  ADDR_W  per-port address.
- WDATA0, WDATA1  in  DATA_W  per-port write data.
- GNT  out  2  one-hot grant; 0 when idle.
- ACK  out  2  one-cycle completion pulse.
- RDATA  out  DATA_W  registered read data; valid while ACK is high, held afterwards.
- MAR_LOAD  out  1  MAR load strobe.
- MAR_ADDR  out  ADDR_W  address presented to the MAR.
- RAM_EN  out  1  RAM enable.
- RAM_RW  out  1  RAM direction; 1 = read, 0 = write.
- RAM_WDATA  out  DATA_W  write data to RAM.
- RAM_RDATA  in  DATA_W  RAM read data; combinationally valid while RAM_EN=1 and RAM_RW=1.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - ADDR: MAR_LOAD=1, MAR_ADDR=latched address.
  - XFER: RAM_EN=1, RAM_RW=latched RW; RAM_WDATA=latched data on writes.
  - DONE: ACK[port]=1.
- All outputs are registered.
- Reset values: GNT=0, ACK=0, RDATA=0, MAR_LOAD=0, MAR_ADDR=0, RAM_EN=0, RAM_RW=1, RAM_WDATA=0, BUSY=0, state=IDLE, burst count=0, last-served pointer=loader.
- Arbitration runs in IDLE and DONE:
  - Only one REQ is high: that port is chosen.
  - Both REQ are high: the port that was not last served is chosen.
  - Lock override: in DONE, if the current port has REQ=1 and LOCK=1, and either burst count < MAX_BURST or the other REQ=0, the same port is kept and burst count increments.
  - Otherwise the normal rule applies and burst count resets to 1.
- On the transition into ADDR, the winning port's RW, address and write data are latched. The requester needs to hold these stable only until GNT rises.
- After the latch, dropping REQ does not abort the access; XFER and the ACK still occur.
- Read data: RAM_RDATA is sampled on the edge that ends XFER and appears on RDATA in DONE.
- Writes leave RDATA unchanged.
- GNT stays high through ADDR, XFER and DONE.
- In DONE, if nothing is chosen, the next state is IDLE and GNT=0.
- A lock by a sole requester never expires.

## Timing
- REQ sampled high in IDLE at edge N:
  - ADDR during cycle N+1.
  - XFER during N+2.
  - DONE (ACK) during N+3.
- Back-to-back transfers: DONE goes directly to ADDR, giving one transfer every 3 cycles and no idle cycle.
- RAM_EN is high for exactly one cycle per access. MAR_LOAD always precedes RAM_EN by exactly one cycle.
- Reset mid-operation: RST sampled low at any edge forces the reset values from the following cycle.
  - A write in progress during the cycle in which RST is sampled completes at the RAM.
  - No ACK is issued for an aborted access.
  - The first tie after reset goes to the CPU.

## Structure
- Shared package bat_pkg holds:
  - arbiter state enum {IDLE, ADDR, XFER, DONE}
  - PORT_CPU=0, PORT_LDR=1
  - RW_READ=1, RW_WRITE=0
- One combinational sub-module, bat_rr_pick. Inputs: REQ, LOCK, current port, last-served port, burst-limit flag. Outputs: chosen port and valid.
- The top level contains the FSM, latches, burst counter and output registers.

## Test plan
- CPU read of 0x12 with RAM[0x12]=0xABCD, REQ=01 at edge N:
  - N+1: GNT=01, MAR_LOAD=1, MAR_ADDR=0x12.
  - N+2: RAM_EN=1, RAM_RW=1.
  - N+3: ACK=01, RDATA=0xABCD.
- Loader write of 0x5A5A to 0x40: RAM_EN=1, RAM_RW=0, RAM_WDATA=0x5A5A for exactly one cycle; ACK=10 the following cycle; RDATA unchanged.
- REQ=11 right after reset: CPU is served first with ACK at N+3, then the loader with ACK at N+6; GNT sequence is 01 then 10, with no IDLE cycle between.
- Loader asserts LOCK with 6 queued writes while CPU REQ is held, MAX_BURST=4: exactly 4 loader ACKs, then the CPU is granted. Repeating with CPU idle gives all 6 loader writes back-to-back.
- Requester drops REQ in the cycle after GNT rises: the access still completes and the ACK pulses once.
- RST low during XFER of a read: outputs reach reset values the next cycle and no ACK is issued. A new CPU request is then served with 3-cycle latency.

Source files
------------

// File: rtl/bat_pkg.sv
// Shared types and constants for the BAT MAR/RAM arbiter.
package bat_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        XFER,
        DONE
    } bat_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bat_rr_pick.sv
// Round-robin port selection with lock retention; purely combinational.
module bat_rr_pick
    import bat_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       cur,
    input  logic       last,
    input  logic       burst_lim,
    output logic       pick,
    output logic       valid
);

    logic other;

    always_comb begin
        other = ~cur;
        valid = |req;
        pick  = PORT_CPU;
        // A sole locked requester is never forced to yield.
        if (req[cur] && lock[cur] && (!burst_lim || !req[other])) begin
            pick = cur;
        end else if (&req) begin
            pick = ~last;
        end else if (req[PORT_LDR]) begin
            pick = PORT_LDR;
        end else begin
            pick = PORT_CPU;
        end
    end

endmodule

// File: rtl/bat_ram_arbiter.sv
// Two-port MAR/RAM arbiter: grants one requester, sequences MAR load then RAM
// enable, and returns read data alongside a one-cycle acknowledge.
module bat_ram_arbiter
    import bat_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        REQ,
    input  logic [1:0]        LOCK,
    input  logic [1:0]        RW,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic [1:0]        GNT,
    output logic [1:0]        ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              MAR_LOAD,
    output logic [ADDR_W-1:0] MAR_ADDR,
    output logic              RAM_EN,
    output logic              RAM_RW,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic              BUSY
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    bat_state_t        state_reg, state_next;
    logic              cur_reg, cur_next;
    logic              last_reg, last_next;
    logic [BW-1:0]     burst_reg, burst_next;
    logic              rw_lat_reg, rw_lat_next;
    logic [DATA_W-1:0] wdata_lat_reg, wdata_lat_next;
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        ack_reg, ack_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              mar_load_reg, mar_load_next;
    logic [ADDR_W-1:0] mar_addr_reg, mar_addr_next;
    logic              ram_en_reg, ram_en_next;
    logic              ram_rw_reg, ram_rw_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic              busy_reg, busy_next;

    logic [1:0] lock_eff;
    logic       burst_lim;
    logic       pick;
    logic       pick_valid;
    logic       keep;

    // Lock only matters at the end of a transfer; IDLE arbitration ignores it.
    assign lock_eff  = (state_reg == DONE) ? LOCK : 2'b00;
    assign burst_lim = (burst_reg >= BURST_MAX);

    bat_rr_pick u_pick (
        .req       (REQ),
        .lock      (lock_eff),
        .cur       (cur_reg),
        .last      (last_reg),
        .burst_lim (burst_lim),
        .pick      (pick),
        .valid     (pick_valid)
    );

    // Re-picking the current port with its lock asserted can only come from
    // the lock override: the plain tie rule would have chosen the other port.
    assign keep = pick_valid && (pick == cur_reg) && lock_eff[cur_reg];

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        last_next      = last_reg;
        burst_next     = burst_reg;
        rw_lat_next    = rw_lat_reg;
        wdata_lat_next = wdata_lat_reg;
        gnt_next       = gnt_reg;
        ack_next       = 2'b00;
        rdata_next     = rdata_reg;
        mar_load_next  = 1'b0;
        mar_addr_next  = mar_addr_reg;
        ram_en_next    = 1'b0;
        ram_rw_next    = RW_READ;
        ram_wdata_next = ram_wdata_reg;

        case (state_reg)
            IDLE, DONE: begin
                gnt_next   = 2'b00;
                state_next = IDLE;
                if (pick_valid) begin
                    state_next     = ADDR;
                    cur_next       = pick;
                    last_next      = pick;
                    gnt_next       = port_onehot(pick);
                    rw_lat_next    = RW[pick];
                    wdata_lat_next = pick ? WDATA1 : WDATA0;
                    mar_addr_next  = pick ? ADDR1 : ADDR0;
                    mar_load_next  = 1'b1;
                    if (keep) begin
                        burst_next = (burst_reg == BURST_MAX) ? burst_reg
                                                              : burst_reg + BW'(1);
                    end else begin
                        burst_next = BW'(1);
                    end
                end
            end
            ADDR: begin
                state_next  = XFER;
                ram_en_next = 1'b1;
                ram_rw_next = rw_lat_reg;
                if (rw_lat_reg == RW_WRITE) begin
                    ram_wdata_next = wdata_lat_reg;
                end
            end
            XFER: begin
                state_next = DONE;
                ack_next   = port_onehot(cur_reg);
                if (rw_lat_reg == RW_READ) begin
                    rdata_next = RAM_RDATA;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cur_reg       <= PORT_CPU;
            last_reg      <= PORT_LDR;
            burst_reg     <= '0;
            rw_lat_reg    <= RW_READ;
            wdata_lat_reg <= '0;
            gnt_reg       <= 2'b00;
            ack_reg       <= 2'b00;
            rdata_reg     <= '0;
            mar_load_reg  <= 1'b0;
            mar_addr_reg  <= '0;
            ram_en_reg    <= 1'b0;
            ram_rw_reg    <= RW_READ;
            ram_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            last_reg      <= last_next;
            burst_reg     <= burst_next;
            rw_lat_reg    <= rw_lat_next;
            wdata_lat_reg <= wdata_lat_next;
            gnt_reg       <= gnt_next;
            ack_reg       <= ack_next;
            rdata_reg     <= rdata_next;
            mar_load_reg  <= mar_load_next;
            mar_addr_reg  <= mar_addr_next;
            ram_en_reg    <= ram_en_next;
            ram_rw_reg    <= ram_rw_next;
            ram_wdata_reg <= ram_wdata_next;
            busy_reg      <= busy_next;
        end
    end

    assign GNT       = gnt_reg;
    assign ACK       = ack_reg;
    assign RDATA     = rdata_reg;
    assign MAR_LOAD  = mar_load_reg;
    assign MAR_ADDR  = mar_addr_reg;
    assign RAM_EN    = ram_en_reg;
    assign RAM_RW    = ram_rw_reg;
    assign RAM_WDATA = ram_wdata_reg;
    assign BUSY      = busy_reg;

endmodule
